// File: rtl/multi_blinky.sv
// multi_blinky: NUM_CH independent LED channels (OFF/ON/BLINK/BURST) behind a valid/ready config port.
// Build option MULTI_BLINKY_GLOBAL_SYNC_EN adds sync_i, which restarts every blinking channel at once.

module multi_blinky_ch #(
   parameter int CNT_W        = 24,
   parameter int DEFAULT_HALF = 12_000_000,
   parameter int BURST_W      = 4,
   parameter int GAP_HALVES   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_i,
   input  logic               sync_i,
   input  logic [1:0]         mode_i,
   input  logic [CNT_W-1:0]   half_i,
   input  logic [BURST_W-1:0] burst_i,
   output logic               led_o,
   output logic               toggle_o
);
   localparam int GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

   typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_e;
   typedef enum logic [1:0] {B_HI, B_LO, B_GAP} bst_e;

   mode_e              mode_q, mode_d;
   bst_e               bst_q, bst_d;
   logic [CNT_W-1:0]   half_q, half_d, cnt_q, cnt_d;
   logic [BURST_W-1:0] burst_q, burst_d, idx_q, idx_d, idx_inc;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               led_q, led_d, tog_q, tog_d;
   logic               run, run_new;

   always_comb begin
      mode_d  = mode_q;
      half_d  = half_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      bst_d   = bst_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      led_d   = led_q;
      idx_inc = idx_q + BURST_W'(1);
      // A BURST channel with zero pulses is parked exactly like OFF.
      run     = (mode_q == M_BLINK) || ((mode_q == M_BURST) && (burst_q != '0));
      if (wr_i) begin
         mode_d  = mode_e'(mode_i);
         half_d  = (half_i == '0) ? CNT_W'(1) : half_i;
         burst_d = burst_i;
      end
      run_new = (mode_d == M_BLINK) || ((mode_d == M_BURST) && (burst_d != '0));
      if (wr_i || (sync_i && run)) begin
         // Restart takes priority over any tick due this cycle.
         cnt_d = half_d - CNT_W'(1);
         bst_d = B_HI;
         idx_d = '0;
         gap_d = '0;
         led_d = (mode_d == M_ON) || run_new;
      end else if (run) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            cnt_d = half_q - CNT_W'(1);
            if (mode_q == M_BLINK) begin
               led_d = ~led_q;
            end else begin
               case (bst_q)
                  B_HI: begin
                     led_d = 1'b0;
                     bst_d = B_LO;
                  end
                  B_LO: begin
                     idx_d = idx_inc;
                     if (idx_inc == burst_q) begin
                        bst_d = B_GAP;
                        gap_d = '0;
                     end else begin
                        led_d = 1'b1;
                        bst_d = B_HI;
                     end
                  end
                  B_GAP: begin
                     if (gap_q == GAP_W'(GAP_HALVES - 1)) begin
                        led_d = 1'b1;
                        idx_d = '0;
                        bst_d = B_HI;
                     end else begin
                        gap_d = gap_q + GAP_W'(1);
                     end
                  end
                  default: bst_d = B_HI;
               endcase
            end
         end
      end
      tog_d = led_d ^ led_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q  <= M_BLINK;
         half_q  <= CNT_W'(DEFAULT_HALF);
         burst_q <= BURST_W'(1);
         cnt_q   <= CNT_W'(DEFAULT_HALF - 1);
         bst_q   <= B_HI;
         idx_q   <= '0;
         gap_q   <= '0;
         led_q   <= 1'b0;
         tog_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         half_q  <= half_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         bst_q   <= bst_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         led_q   <= led_d;
         tog_q   <= tog_d;
      end
   end

   assign led_o    = led_q;
   assign toggle_o = tog_q;
endmodule

module multi_blinky #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 24,
   parameter int DEFAULT_HALF = 12_000_000,
   parameter int BURST_W      = 4,
   parameter int GAP_HALVES   = 4,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
`ifdef MULTI_BLINKY_GLOBAL_SYNC_EN
   input  logic               sync_i,
`endif
   input  logic               cfg_valid_i,
   output logic               cfg_ready_o,
   input  logic [CH_W-1:0]    cfg_ch_i,
   input  logic [1:0]         cfg_mode_i,
   input  logic [CNT_W-1:0]   cfg_half_i,
   input  logic [BURST_W-1:0] cfg_burst_i,
   output logic [NUM_CH-1:0]  led_o,
   output logic [NUM_CH-1:0]  toggle_o
);
   logic rdy_q;
   logic fire;
   logic sync;

   always_ff @(posedge clk_i) begin
      if (rst_i) rdy_q <= 1'b0;
      else       rdy_q <= 1'b1;
   end

   assign cfg_ready_o = rdy_q;
   assign fire        = cfg_valid_i && rdy_q;
`ifdef MULTI_BLINKY_GLOBAL_SYNC_EN
   assign sync = sync_i;
`else
   assign sync = 1'b0;
`endif

   // Out-of-range channel numbers match no instance, so the write is simply dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      multi_blinky_ch #(
         .CNT_W        (CNT_W),
         .DEFAULT_HALF (DEFAULT_HALF),
         .BURST_W      (BURST_W),
         .GAP_HALVES   (GAP_HALVES)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .wr_i     (fire && (cfg_ch_i == CH_W'(i))),
         .sync_i   (sync),
         .mode_i   (cfg_mode_i),
         .half_i   (cfg_half_i),
         .burst_i  (cfg_burst_i),
         .led_o    (led_o[i]),
         .toggle_o (toggle_o[i])
      );
   end
endmodule

// File: tb/tb_multi_blinky.sv
// Bench for multi_blinky: directed scenarios plus random writes, checked against an elapsed-time LED model.
// A second 3-channel instance shares all inputs, so channel-3 writes exercise the out-of-range path.

module tb_multi_blinky;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 24;
   localparam int DH      = 4;
   localparam int BURST_W = 4;
   localparam int GAP     = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               sync = 1'b0;
   logic               cfg_valid = 1'b0;
   logic [1:0]         cfg_ch = '0;
   logic [1:0]         cfg_mode = '0;
   logic [CNT_W-1:0]   cfg_half = '0;
   logic [BURST_W-1:0] cfg_burst = '0;
   logic               ready, ready3;
   logic [3:0]         led, tog;
   logic [2:0]         led3, tog3;

   always #5 clk = ~clk;

   multi_blinky #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DH), .BURST_W(BURST_W), .GAP_HALVES(GAP)) u_dut (
      .clk_i(clk), .rst_i(rst),
`ifdef MULTI_BLINKY_GLOBAL_SYNC_EN
      .sync_i(sync),
`endif
      .cfg_valid_i(cfg_valid), .cfg_ready_o(ready), .cfg_ch_i(cfg_ch), .cfg_mode_i(cfg_mode),
      .cfg_half_i(cfg_half), .cfg_burst_i(cfg_burst), .led_o(led), .toggle_o(tog));

   multi_blinky #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_HALF(DH), .BURST_W(BURST_W), .GAP_HALVES(GAP)) u_dut3 (
      .clk_i(clk), .rst_i(rst),
`ifdef MULTI_BLINKY_GLOBAL_SYNC_EN
      .sync_i(sync),
`endif
      .cfg_valid_i(cfg_valid), .cfg_ready_o(ready3), .cfg_ch_i(cfg_ch), .cfg_mode_i(cfg_mode),
      .cfg_half_i(cfg_half), .cfg_burst_i(cfg_burst), .led_o(led3), .toggle_o(tog3));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Model: per channel config plus cycles elapsed since the last restart.
   int     m_mode[NUM_CH], m_half[NUM_CH], m_burst[NUM_CH];
   longint m_e[NUM_CH];
   bit     m_rph[NUM_CH];
   bit     m_rdy = 1'b0;
   bit [3:0] m_led = '0, m_tog = '0;

   function automatic bit active(int c);
      return (m_mode[c] == 2) || (m_mode[c] == 3 && m_burst[c] != 0);
   endfunction

   function automatic bit led_of(int c);
      longint k, j, l;
      k = m_e[c] / m_half[c];
      case (m_mode[c])
         0: return 1'b0;
         1: return 1'b1;
         2: return m_rph[c] ? (k % 2 == 1) : (k % 2 == 0);
         default: begin
            if (m_burst[c] == 0) return 1'b0;
            l = 2 * m_burst[c] + GAP;
            j = k % l;
            return (j < 2 * m_burst[c]) && (j % 2 == 0);
         end
      endcase
   endfunction

   task automatic model_step();
      bit fire;
      bit [3:0] nl;
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 2; m_half[c] = DH; m_burst[c] = 1; m_e[c] = 0; m_rph[c] = 1'b1;
         end
         m_rdy = 1'b0; m_led = '0; m_tog = '0;
         return;
      end
      fire = cfg_valid && m_rdy;
      for (int c = 0; c < NUM_CH; c++) begin
         if (fire && int'(cfg_ch) == c) begin
            m_mode[c]  = int'(cfg_mode);
            m_half[c]  = (cfg_half == 0) ? 1 : int'(cfg_half);
            m_burst[c] = int'(cfg_burst);
            m_e[c] = 0; m_rph[c] = 1'b0;
         end else if (sync && active(c)) begin
            m_e[c] = 0; m_rph[c] = 1'b0;
         end else if (active(c)) begin
            m_e[c]++;
         end
         nl[c] = led_of(c);
      end
      m_tog = nl ^ m_led;
      m_led = nl;
      m_rdy = 1'b1;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step();
      chk("led", int'(led), int'(m_led));
      chk("toggle", int'(tog), int'(m_tog));
      chk("ready", int'(ready), int'(m_rdy));
      chk("led3", int'(led3), int'(m_led[2:0]));
      chk("toggle3", int'(tog3), int'(m_tog[2:0]));
      chk("ready3", int'(ready3), int'(m_rdy));
   endtask

   task automatic write(input int ch, input int mode, input int half, input int burst);
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_mode  = 2'(mode);
      cfg_half  = CNT_W'(half);
      cfg_burst = BURST_W'(burst);
      cycle();
      cfg_valid = 1'b0;
   endtask

   // k counts edges since the last reset edge; LEDs rise at k=DH and toggle every DH.
   task automatic reset_seq();
      rst = 1'b1;
      cycle();
      chk("rst_led", int'(led), 0);
      chk("rst_ready", int'(ready), 0);
      rst = 1'b0;
      for (int k = 1; k <= 8 * DH; k++) begin
         cycle();
         chk("seq_led", int'(led), ((k / DH) % 2 == 1) ? 15 : 0);
         chk("seq_tog", int'(tog), (k % DH == 0) ? 15 : 0);
         if (k == 1) chk("seq_ready", int'(ready), 1);
      end
   endtask

   bit pat[10] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};

   initial begin
      cycle();
      reset_seq();

      write(1, 2, 2, 0);
      chk("ch1_on", int'(led[1]), 1);
      for (int i = 1; i < 8; i++) begin
         cycle();
         chk("ch1_blink", int'(led[1]), ((i / 2) % 2 == 0) ? 1 : 0);
      end

      write(2, 3, 1, 3);
      chk("burst", int'(led[2]), int'(pat[0]));
      for (int i = 1; i < 20; i++) begin
         cycle();
         chk("burst", int'(led[2]), int'(pat[i % 10]));
      end

      write(3, 0, 5, 0);
      chk("ch3_off", int'(led[3]), 0);
      cycle();
      write(3, 1, 5, 0);
      chk("ch3_on", int'(led[3]), 1);
      chk("ch3_on_tog", int'(tog[3]), 1);
      cycle();
      chk("ch3_hold_tog", int'(tog[3]), 0);

      write(0, 2, 0, 0);
      for (int i = 1; i < 6; i++) begin
         cycle();
         chk("half0", int'(led[0]), (i % 2 == 0) ? 1 : 0);
      end

      write(2, 3, 2, 2);
      for (int i = 0; i < 5; i++) cycle();
      reset_seq();

      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 399) == 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_mode  = 2'($urandom_range(0, 3));
         cfg_half  = CNT_W'($urandom_range(0, 6));
         cfg_burst = BURST_W'($urandom_range(0, 4));
`ifdef MULTI_BLINKY_GLOBAL_SYNC_EN
         sync      = ($urandom_range(0, 49) == 0);
`endif
         cycle();
      end
      rst = 1'b0;
      cfg_valid = 1'b0;
      sync = 1'b0;

`ifdef MULTI_BLINKY_GLOBAL_SYNC_EN
      write(0, 2, 3, 0);
      write(1, 2, 5, 0);
      for (int i = 0; i < 7; i++) cycle();
      sync = 1'b1;
      cycle();
      sync = 1'b0;
      chk("sync_led", int'(led[1:0]), 3);
      for (int i = 1; i <= 5; i++) begin
         cycle();
         chk("sync_ch0", int'(led[0]), (i >= 3) ? 0 : 1);
         chk("sync_ch1", int'(led[1]), (i >= 5) ? 0 : 1);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
